// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock alarm path: field widths, wrap limits,
// FSM state and edit-field codes, and the wrap-around step helper.
package clock_pkg;

    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned TIMER_W = 9;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;

    typedef enum logic [2:0] {
        StDisp,
        StSetHour,
        StSetMin,
        StRing,
        StSnooze
    } alarm_state_e;

    typedef enum logic [1:0] {
        FieldNone = 2'd0,
        FieldHour = 2'd1,
        FieldMin  = 2'd2
    } edit_field_e;

    // Single decoded button action after priority resolution.
    typedef enum logic [1:0] {
        BtnNone,
        BtnSet,
        BtnDown,
        BtnUp
    } btn_e;

    // Step val by one toward up/down, wrapping between 0 and max.
    function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max,
                                             input logic up);
        if (up) begin
            return (val >= max) ? 6'd0 : val + 6'd1;
        end else begin
            return (val == 6'd0) ? max : val - 6'd1;
        end
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable seconds down-counter. Load has priority over the tick decrement and the
// count holds at zero instead of wrapping.
module alarm_timer
    import clock_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    // Count register: load, else decrement once per tick while non-zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alarm_controller.sv
// Alarm time editing, arming and ring/snooze/dismiss sequencing for the digital clock.
// Build option: define ALARM_SNOOZE_EN to include the snooze state and snooze counter;
// without it, up is ignored while ringing and the ring timeout always dismisses.
module alarm_controller
    import clock_pkg::*;
#(
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned SNOOZE_MAX     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              enable,
    input  logic              pulsed_set,
    input  logic              pulsed_up,
    input  logic              pulsed_down,
    input  logic [HOUR_W-1:0] clk24_hours,
    input  logic [MIN_W-1:0]  clk24_minutes,
    input  logic [SEC_W-1:0]  clk24_seconds,
    output logic [HOUR_W-1:0] alarm_hours,
    output logic [MIN_W-1:0]  alarm_minutes,
    output logic [HOUR_W-1:0] edit_hours,
    output logic [MIN_W-1:0]  edit_minutes,
    output logic [1:0]        edit_field,
    output logic              alarm_armed,
    output logic              alarm_ringing,
    output logic              in_disp_state
);

    localparam logic [TIMER_W-1:0] RING_LOAD = TIMER_W'(RING_TIMEOUT_S);

    alarm_state_e      state_q, state_d;
    logic [HOUR_W-1:0] alarm_hours_q, alarm_hours_d;
    logic [MIN_W-1:0]  alarm_minutes_q, alarm_minutes_d;
    logic [HOUR_W-1:0] edit_hours_q, edit_hours_d;
    logic [MIN_W-1:0]  edit_minutes_q, edit_minutes_d;
    logic              armed_q, armed_d;
    logic              match_q;
    logic [1:0]        edit_field_q;
    logic              ringing_q;
    logic              in_disp_q;

    btn_e               btn;
    logic               match;
    logic               ring_start;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_zero;
    logic [TIMER_W-1:0] timer_count_unused;

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SNZ_W = (SNOOZE_MAX < 2) ? 1 : $clog2(SNOOZE_MAX + 1);
    localparam logic [SNZ_W-1:0]   SNZ_LIMIT   = SNZ_W'(SNOOZE_MAX);
    localparam logic [TIMER_W-1:0] SNOOZE_LOAD = TIMER_W'(SNOOZE_S);

    logic [SNZ_W-1:0] snooze_cnt_q, snooze_cnt_d;
    logic             snooze_ok;

    assign snooze_ok = (snooze_cnt_q < SNZ_LIMIT);
`else
    logic unused_snooze_cfg;

    assign unused_snooze_cfg = (SNOOZE_S != 0) ^ (SNOOZE_MAX != 0);
`endif

    // Resolve simultaneous button pulses: set beats down beats up.
    always_comb begin
        btn = BtnNone;
        if (pulsed_set) begin
            btn = BtnSet;
        end else if (pulsed_down) begin
            btn = BtnDown;
        end else if (pulsed_up) begin
            btn = BtnUp;
        end
    end

    // Alarm fires only on the rising edge of the time match, so it rings once per event.
    assign match      = (clk24_hours == alarm_hours_q) && (clk24_minutes == alarm_minutes_q) &&
                        (clk24_seconds == '0);
    assign ring_start = armed_q && match && !match_q;

    // Next-state, shadow/commit registers and timer load requests.
    always_comb begin
        state_d         = state_q;
        alarm_hours_d   = alarm_hours_q;
        alarm_minutes_d = alarm_minutes_q;
        edit_hours_d    = edit_hours_q;
        edit_minutes_d  = edit_minutes_q;
        armed_d         = armed_q;
        timer_load      = 1'b0;
        timer_val       = '0;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_d    = snooze_cnt_q;
`endif

        unique case (state_q)
            StDisp: begin
                if (ring_start) begin
                    state_d    = StRing;
                    timer_load = 1'b1;
                    timer_val  = RING_LOAD;
                end else if (enable) begin
                    if (btn == BtnSet) begin
                        edit_hours_d   = alarm_hours_q;
                        edit_minutes_d = alarm_minutes_q;
                        state_d        = StSetHour;
                    end else if (btn == BtnUp) begin
                        armed_d = !armed_q;
                    end
                end
            end

            StSetHour: begin
                if (!enable) begin
                    state_d = StDisp;
                end else begin
                    unique case (btn)
                        BtnSet:  state_d = StSetMin;
                        BtnUp:   edit_hours_d = HOUR_W'(wrap_step({1'b0, edit_hours_q},
                                                                  HOUR_MAX, 1'b1));
                        BtnDown: edit_hours_d = HOUR_W'(wrap_step({1'b0, edit_hours_q},
                                                                  HOUR_MAX, 1'b0));
                        BtnNone: ;
                    endcase
                end
            end

            StSetMin: begin
                if (!enable) begin
                    state_d = StDisp;
                end else begin
                    unique case (btn)
                        BtnSet: begin
                            alarm_hours_d   = edit_hours_q;
                            alarm_minutes_d = edit_minutes_q;
                            armed_d         = 1'b1;
                            state_d         = StDisp;
                        end
                        BtnUp:   edit_minutes_d = wrap_step(edit_minutes_q, MIN_MAX, 1'b1);
                        BtnDown: edit_minutes_d = wrap_step(edit_minutes_q, MIN_MAX, 1'b0);
                        BtnNone: ;
                    endcase
                end
            end

            StRing: begin
                // Buttons act here regardless of enable so the alarm can always be silenced.
                if (btn == BtnDown) begin
                    state_d    = StDisp;
                    timer_load = 1'b1;
`ifdef ALARM_SNOOZE_EN
                    snooze_cnt_d = '0;
`endif
                end else begin
`ifdef ALARM_SNOOZE_EN
                    if (((btn == BtnUp) || timer_zero) && snooze_ok) begin
                        state_d      = StSnooze;
                        snooze_cnt_d = snooze_cnt_q + SNZ_W'(1);
                        timer_load   = 1'b1;
                        timer_val    = SNOOZE_LOAD;
                    end else if (timer_zero) begin
                        state_d      = StDisp;
                        snooze_cnt_d = '0;
                    end
`else
                    if (timer_zero) begin
                        state_d = StDisp;
                    end
`endif
                end
            end

`ifdef ALARM_SNOOZE_EN
            StSnooze: begin
                if (btn == BtnDown) begin
                    state_d      = StDisp;
                    snooze_cnt_d = '0;
                    timer_load   = 1'b1;
                end else if (timer_zero) begin
                    state_d    = StRing;
                    timer_load = 1'b1;
                    timer_val  = RING_LOAD;
                end
            end
`endif

            default: state_d = StDisp;
        endcase
    end

    // State and data registers; display/buzzer outputs are registered from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StDisp;
            alarm_hours_q   <= '0;
            alarm_minutes_q <= '0;
            edit_hours_q    <= '0;
            edit_minutes_q  <= '0;
            armed_q         <= 1'b0;
            match_q         <= 1'b0;
            edit_field_q    <= FieldNone;
            ringing_q       <= 1'b0;
            in_disp_q       <= 1'b1;
        end else begin
            state_q         <= state_d;
            alarm_hours_q   <= alarm_hours_d;
            alarm_minutes_q <= alarm_minutes_d;
            edit_hours_q    <= edit_hours_d;
            edit_minutes_q  <= edit_minutes_d;
            armed_q         <= armed_d;
            match_q         <= match;
            ringing_q       <= (state_d == StRing);
            in_disp_q       <= (state_d == StDisp);
            if (state_d == StSetHour) begin
                edit_field_q <= FieldHour;
            end else if (state_d == StSetMin) begin
                edit_field_q <= FieldMin;
            end else begin
                edit_field_q <= FieldNone;
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snoozes used in the current alarm event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snooze_cnt_q <= '0;
        end else begin
            snooze_cnt_q <= snooze_cnt_d;
        end
    end
`endif

    // Ring and snooze durations; the count itself is kept only for debug visibility.
    alarm_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (tick_1hz),
        .count    (timer_count_unused),
        .zero     (timer_zero)
    );

    assign alarm_hours   = alarm_hours_q;
    assign alarm_minutes = alarm_minutes_q;
    assign edit_hours    = edit_hours_q;
    assign edit_minutes  = edit_minutes_q;
    assign edit_field    = edit_field_q;
    assign alarm_armed   = armed_q;
    assign alarm_ringing = ringing_q;
    assign in_disp_state = in_disp_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: table of button vectors for editing/arming,
// then hand-written sequences for matching, timeout, snooze and asynchronous reset.
module tb_alarm_controller;

    logic       clk;
    logic       reset;
    logic       tick_1hz;
    logic       enable;
    logic       pulsed_set;
    logic       pulsed_up;
    logic       pulsed_down;
    logic [4:0] clk24_hours;
    logic [5:0] clk24_minutes;
    logic [5:0] clk24_seconds;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [4:0] edit_hours;
    logic [5:0] edit_minutes;
    logic [1:0] edit_field;
    logic       alarm_armed;
    logic       alarm_ringing;
    logic       in_disp_state;

    int n_vec;
    int n_bad;

    alarm_controller dut (
        .clk           (clk),
        .reset         (reset),
        .tick_1hz      (tick_1hz),
        .enable        (enable),
        .pulsed_set    (pulsed_set),
        .pulsed_up     (pulsed_up),
        .pulsed_down   (pulsed_down),
        .clk24_hours   (clk24_hours),
        .clk24_minutes (clk24_minutes),
        .clk24_seconds (clk24_seconds),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .edit_hours    (edit_hours),
        .edit_minutes  (edit_minutes),
        .edit_field    (edit_field),
        .alarm_armed   (alarm_armed),
        .alarm_ringing (alarm_ringing),
        .in_disp_state (in_disp_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, set, up, down;
        logic       cmp_edit;
        logic [1:0] field;
        logic [4:0] eh;
        logic [5:0] em;
        logic [4:0] ah;
        logic [5:0] am;
        logic       armed, ring, disp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic s, input logic u, input logic d,
                       input logic ce, input logic [1:0] f, input logic [4:0] eh,
                       input logic [5:0] em, input logic [4:0] ah, input logic [5:0] am,
                       input logic ar, input logic rg, input logic dp);
        vec_t v;
        v.en = en; v.set = s; v.up = u; v.down = d; v.cmp_edit = ce; v.field = f;
        v.eh = eh; v.em = em; v.ah = ah; v.am = am; v.armed = ar; v.ring = rg; v.disp = dp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs settle 1 ns later and one-shot inputs are cleared.
    task automatic step();
        @(posedge clk);
        #1;
        pulsed_set  = 1'b0;
        pulsed_up   = 1'b0;
        pulsed_down = 1'b0;
        tick_1hz    = 1'b0;
    endtask

    task automatic press(input logic s, input logic u, input logic d);
        pulsed_set  = s;
        pulsed_up   = u;
        pulsed_down = d;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        clk24_hours   = h;
        clk24_minutes = m;
        clk24_seconds = s;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #4;
    endtask

    initial begin
        logic [31:0] act;
        logic [31:0] exp;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        tick_1hz = 1'b0;
        enable = 1'b1;
        pulsed_set = 1'b0;
        pulsed_up = 1'b0;
        pulsed_down = 1'b0;
        set_time(5'd12, 6'd0, 6'd5);

        // en set up dn cmp_edit field eh em ah am armed ring disp
        add(1, 0, 0, 0, 1, 0,  0,  0, 0,  0, 0, 0, 1);  // idle after reset
        add(1, 1, 0, 0, 1, 1,  0,  0, 0,  0, 0, 0, 0);  // enter SET_HOUR
        add(1, 0, 1, 0, 1, 1,  1,  0, 0,  0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1,  2,  0, 0,  0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1,  3,  0, 0,  0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 2,  3,  0, 0,  0, 0, 0, 0);  // to SET_MIN
        add(1, 0, 0, 1, 1, 2,  3, 59, 0,  0, 0, 0, 0);  // 0 -> 59
        add(1, 0, 0, 1, 1, 2,  3, 58, 0,  0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,  3, 58, 3, 58, 1, 0, 1);  // commit 03:58, armed
        add(1, 1, 0, 0, 1, 1,  3, 58, 3, 58, 1, 0, 0);  // edit copies alarm
        add(1, 0, 0, 1, 1, 1,  2, 58, 3, 58, 1, 0, 0);
        add(1, 0, 0, 1, 1, 1,  1, 58, 3, 58, 1, 0, 0);
        add(1, 0, 0, 1, 1, 1,  0, 58, 3, 58, 1, 0, 0);
        add(1, 0, 0, 1, 1, 1, 23, 58, 3, 58, 1, 0, 0);  // hour 0 -> 23
        add(1, 0, 1, 0, 1, 1,  0, 58, 3, 58, 1, 0, 0);  // hour 23 -> 0
        add(1, 0, 0, 1, 1, 1, 23, 58, 3, 58, 1, 0, 0);
        add(1, 0, 1, 1, 1, 1, 22, 58, 3, 58, 1, 0, 0);  // down beats up
        add(1, 1, 0, 1, 1, 2, 22, 58, 3, 58, 1, 0, 0);  // set beats down
        add(1, 0, 1, 0, 1, 2, 22, 59, 3, 58, 1, 0, 0);
        add(1, 0, 1, 0, 1, 2, 22,  0, 3, 58, 1, 0, 0);  // minute 59 -> 0
        add(1, 0, 0, 1, 1, 2, 22, 59, 3, 58, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0,  0, 3, 58, 1, 0, 1);  // abort, alarm unchanged
        add(1, 0, 1, 0, 0, 0,  0,  0, 3, 58, 0, 0, 1);  // disarm
        add(0, 0, 1, 0, 0, 0,  0,  0, 3, 58, 0, 0, 1);  // up ignored when disabled
        add(1, 0, 1, 0, 0, 0,  0,  0, 3, 58, 1, 0, 1);  // re-arm
        add(1, 0, 0, 1, 0, 0,  0,  0, 3, 58, 1, 0, 1);  // down no effect in DISP
        add(1, 1, 1, 0, 1, 1,  3, 58, 3, 58, 1, 0, 0);  // set+up: SET_HOUR, armed kept
        add(0, 0, 0, 0, 0, 0,  0,  0, 3, 58, 1, 0, 1);  // abort
        add(0, 1, 0, 0, 0, 0,  0,  0, 3, 58, 1, 0, 1);  // set ignored when disabled

        // Outputs while reset is held.
        #12;
        check("reset_vals", {edit_field, edit_hours, edit_minutes, alarm_hours, alarm_minutes,
                             alarm_armed, alarm_ringing, in_disp_state},
              32'h0000_0001);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en;
            press(vecs[i].set, vecs[i].up, vecs[i].down);
            act = {5'd0, edit_field,
                   vecs[i].cmp_edit ? edit_hours : 5'd0,
                   vecs[i].cmp_edit ? edit_minutes : 6'd0,
                   alarm_hours, alarm_minutes, alarm_armed, alarm_ringing, in_disp_state};
            exp = {5'd0, vecs[i].field,
                   vecs[i].cmp_edit ? vecs[i].eh : 5'd0,
                   vecs[i].cmp_edit ? vecs[i].em : 6'd0,
                   vecs[i].ah, vecs[i].am, vecs[i].armed, vecs[i].ring, vecs[i].disp};
            check($sformatf("vec%0d", i), act, exp);
        end

        // Program 07:30 from a fresh reset.
        do_reset();
        enable = 1'b1;
        press(1, 0, 0);
        for (int i = 0; i < 7; i++) press(0, 1, 0);
        press(1, 0, 0);
        for (int i = 0; i < 30; i++) press(0, 1, 0);
        press(1, 0, 0);
        check("prog_0730", {alarm_hours, alarm_minutes, alarm_armed}, {5'd7, 6'd30, 1'b1});

        set_time(5'd7, 6'd29, 6'd59);
        step();
        step();
        check("pre_match", 32'(alarm_ringing), 32'd0);
        set_time(5'd7, 6'd30, 6'd0);
        step();
        check("ring_one_clk", {alarm_ringing, in_disp_state}, 2'b10);
        press(0, 0, 1);
        check("dismiss", {alarm_ringing, in_disp_state}, 2'b01);
        for (int i = 0; i < 5; i++) step();
        check("no_retrigger", 32'(alarm_ringing), 32'd0);
        set_time(5'd7, 6'd30, 6'd1);
        step();
        set_time(5'd7, 6'd30, 6'd0);
        step();
        check("rearm_edge", 32'(alarm_ringing), 32'd1);

`ifndef ALARM_SNOOZE_EN
        press(0, 1, 0);
        check("up_ignored", {alarm_ringing, in_disp_state}, 2'b10);
        ticks(59);
        step();
        check("timeout_59", 32'(alarm_ringing), 32'd1);
        ticks(1);
        step();
        check("timeout_60", {alarm_ringing, in_disp_state}, 2'b01);
`else
        for (int k = 1; k <= 3; k++) begin
            press(0, 1, 0);
            check($sformatf("snooze%0d", k), {alarm_ringing, in_disp_state}, 2'b00);
            ticks(299);
            step();
            check($sformatf("snooze%0d_299", k), 32'(alarm_ringing), 32'd0);
            ticks(1);
            step();
            check($sformatf("snooze%0d_300", k), 32'(alarm_ringing), 32'd1);
        end
        press(0, 1, 0);
        check("snooze_max", 32'(alarm_ringing), 32'd1);
        ticks(59);
        step();
        check("final_59", 32'(alarm_ringing), 32'd1);
        ticks(1);
        step();
        check("final_dismiss", {alarm_ringing, in_disp_state}, 2'b01);
        set_time(5'd7, 6'd30, 6'd1);
        step();
        set_time(5'd7, 6'd30, 6'd0);
        step();
        press(0, 1, 0);
        press(0, 0, 1);
        check("snooze_down", {alarm_ringing, in_disp_state}, 2'b01);
`endif

        // Asynchronous reset in the middle of a ring.
        set_time(5'd7, 6'd30, 6'd1);
        step();
        set_time(5'd7, 6'd30, 6'd0);
        step();
        check("ring_before_rst", 32'(alarm_ringing), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {alarm_ringing, alarm_armed, in_disp_state, alarm_hours},
              {1'b0, 1'b0, 1'b1, 5'd0});
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
